// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit behind the decoder.
//   Takes one decoded load/store (memRW, funct3, ALU address, rs2). It runs a
//   req/gnt/rvalid handshake to data memory and builds the byte enables and
//   the lane-replicated store data. Load data is sign- or zero-extended for
//   writeback. The core is held via stall_o until the access finishes.
//   Misaligned or illegal accesses are rejected in the same cycle without a
//   bus request. An access that runs too long is aborted with err_o.
// Ports:
//   clk_i, rst_ni               clock, async active-low reset
//   req_valid_i, mem_we_i       access present / store(1) vs load(0)
//   ld_st_sel_i                 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   addr_i, wdata_i             byte address, store data
//   stall_o, done_o             hold pipeline / one-cycle completion pulse
//   rdata_o                     extended load result, held until next load
//   misaligned_o, err_o         rejected access / bus timeout (pulse with done_o)
//   dmem_*                      data memory request/response channel
module lsu_ctrl #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  input  logic        mem_we_i,
  input  logic [2:0]  ld_st_sel_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        misaligned_o,
  output logic        err_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, RESP} state_e;

  // Last counter value before the abort; the counter starts at 0 on entering
  // REQ, so the access gets exactly TIMEOUT_CYC cycles in REQ+WAIT_R.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [2:0]  sel_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic        err_q, err_d;
  logic        accept, reject, capture;
  logic        sel_legal, mis;
  logic [3:0]  be;
  logic [31:0] wdata_rep, ld_ext;

  // Legality and alignment of the incoming request.
  always_comb begin
    sel_legal = (ld_st_sel_i == 3'b000) || (ld_st_sel_i == 3'b001) ||
                (ld_st_sel_i == 3'b010) || (ld_st_sel_i == 3'b100) ||
                (ld_st_sel_i == 3'b101);
    mis = ((ld_st_sel_i[1:0] == 2'b01) && addr_i[0]) ||
          ((ld_st_sel_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
    accept = (state_q == IDLE) && req_valid_i && sel_legal && !mis;
    reject = (state_q == IDLE) && req_valid_i && (!sel_legal || mis);
  end

  // Byte enables and replicated store data from the latched request.
  always_comb begin
    be        = 4'b1111;
    wdata_rep = wdata_q;
    case (sel_q[1:0])
      2'b00: begin
        be        = 4'b0001 << addr_q[1:0];
        wdata_rep = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be        = 4'b0011 << {addr_q[1], 1'b0};
        wdata_rep = {2{wdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane extraction and extension of the returning load data.
  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    b = dmem_rdata_i[8*addr_q[1:0] +: 8];
    h = dmem_rdata_i[16*addr_q[1] +: 16];
    case (sel_q)
      3'b000:  ld_ext = {{24{b[7]}}, b};
      3'b001:  ld_ext = {{16{h[15]}}, h};
      3'b100:  ld_ext = {24'h0, b};
      3'b101:  ld_ext = {16'h0, h};
      default: ld_ext = dmem_rdata_i;
    endcase
  end

  // Next state. A completing handshake wins over the timeout in the same cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = REQ;
          cnt_d   = 8'd0;
          err_d   = 1'b0;
        end
      end
      REQ: begin
        if (dmem_gnt_i && (we_q || dmem_rvalid_i)) begin
          state_d = RESP;
          capture = !we_q;
        end else if (cnt_q == TO_LAST) begin
          state_d = RESP;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (dmem_gnt_i) state_d = WAIT_R;
        end
      end
      WAIT_R: begin
        if (dmem_rvalid_i) begin
          state_d = RESP;
          capture = 1'b1;
        end else if (cnt_q == TO_LAST) begin
          state_d = RESP;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= 3'b000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (accept) begin
        we_q    <= mem_we_i;
        sel_q   <= ld_st_sel_i;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
      end
      if (capture) rdata_q <= ld_ext;
    end
  end

  // Outputs. Bus fields are gated to REQ so they read 0 outside a request.
  always_comb begin
    dmem_req_o   = (state_q == REQ);
    dmem_we_o    = dmem_req_o && we_q;
    dmem_addr_o  = dmem_req_o ? {addr_q[31:2], 2'b00} : 32'h0;
    dmem_be_o    = dmem_req_o ? be : 4'b0000;
    dmem_wdata_o = dmem_req_o ? wdata_rep : 32'h0;
    stall_o      = accept || (state_q == REQ) || (state_q == WAIT_R);
    misaligned_o = reject;
    done_o       = (state_q == RESP) || reject;
    err_o        = (state_q == RESP) && err_q;
    rdata_o      = rdata_q;
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;
  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, mem_we;
  logic [2:0]  sel;
  logic [31:0] addr, wdata;
  logic        stall, done, misal, err;
  logic [31:0] rdata;
  logic        dreq, dwe, gnt, rvalid;
  logic [31:0] daddr, dwdata, drdata;
  logic [3:0]  dbe;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_rdata = 32'h0;

  always #5 clk = ~clk;

  lsu_ctrl #(.TIMEOUT_CYC(T)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .mem_we_i(mem_we),
    .ld_st_sel_i(sel), .addr_i(addr), .wdata_i(wdata), .stall_o(stall),
    .done_o(done), .rdata_o(rdata), .misaligned_o(misal), .err_o(err),
    .dmem_req_o(dreq), .dmem_we_o(dwe), .dmem_addr_o(daddr), .dmem_be_o(dbe),
    .dmem_wdata_o(dwdata), .dmem_gnt_i(gnt), .dmem_rvalid_i(rvalid),
    .dmem_rdata_i(drdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference rules computed directly from the access description.
  function automatic logic [3:0] ref_be(input logic [2:0] s, input logic [31:0] a);
    int k;
    k = (s == 3'b010) ? 4 : ((s == 3'b001 || s == 3'b101) ? 2 : 1);
    if (k == 4) return 4'hF;
    if (k == 2) return (a[1] ? 4'b1100 : 4'b0011);
    return 4'(1 << a[1:0]);
  endfunction

  function automatic logic [31:0] ref_wd(input logic [2:0] s, input logic [31:0] w);
    if (s == 3'b010) return w;
    if (s == 3'b001 || s == 3'b101) return {w[15:0], w[15:0]};
    return {w[7:0], w[7:0], w[7:0], w[7:0]};
  endfunction

  function automatic logic [31:0] ref_ld(input logic [2:0] s, input logic [31:0] a,
                                         input logic [31:0] d);
    logic [31:0] b, h;
    b = (d >> (8 * a[1:0])) & 32'hFF;
    h = (d >> (16 * a[1])) & 32'hFFFF;
    case (s)
      3'b000:  return b[7]  ? (b | 32'hFFFFFF00) : b;
      3'b001:  return h[15] ? (h | 32'hFFFF0000) : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return d;
    endcase
  endfunction

  // One access. g = REQ cycle of gnt, r = extra cycles from gnt to rvalid.
  task automatic access(input logic we, input logic [2:0] s, input logic [31:0] a,
                        input logic [31:0] w, input int g, input int r,
                        input logic [31:0] rd);
    bit legal, bad_al, ok;
    int len;
    legal  = (s == 3'b000 || s == 3'b001 || s == 3'b010 || s == 3'b100 || s == 3'b101);
    bad_al = ((s == 3'b001 || s == 3'b101) && a[0]) || (s == 3'b010 && a[1:0] != 2'b00);
    @(negedge clk);
    req_valid = 1'b1; mem_we = we; sel = s; addr = a; wdata = w;
    #1;
    if (!legal || bad_al) begin
      chk("rej_misal", misal, 1);
      chk("rej_done", done, 1);
      chk("rej_stall", stall, 0);
      chk("rej_req", dreq, 0);
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      chk("rej_req_after", dreq, 0);
      chk("rej_done_after", done, 0);
      return;
    end
    chk("acc_stall", stall, 1);
    chk("acc_done", done, 0);
    chk("acc_misal", misal, 0);
    ok  = we ? (g < T) : (g + r < T);
    len = !ok ? T : (we ? g + 1 : g + r + 1);
    for (int c = 0; c <= len; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      gnt       = (c == g);
      rvalid    = !we && (c == g + r);
      drdata    = rvalid ? rd : $urandom;
      #1;
      if (c < len) begin
        chk("busy_stall", stall, 1);
        chk("busy_done", done, 0);
        chk("busy_req", dreq, (c <= g) ? 1 : 0);
        if (c <= g) begin
          chk("bus_be", dbe, ref_be(s, a));
          chk("bus_addr", daddr, {a[31:2], 2'b00});
          chk("bus_we", dwe, we);
          if (we) chk("bus_wdata", dwdata, ref_wd(s, w));
        end
      end else begin
        if (ok && !we) exp_rdata = ref_ld(s, a, rd);
        chk("end_done", done, 1);
        chk("end_stall", stall, 0);
        chk("end_req", dreq, 0);
        chk("end_err", err, ok ? 0 : 1);
        chk("end_rdata", rdata, exp_rdata);
      end
    end
    @(negedge clk);
    gnt = 1'b0; rvalid = 1'b0;
    #1;
    chk("post_done", done, 0);
    chk("post_rdata", rdata, exp_rdata);
  endtask

  initial begin
    logic [2:0] s;
    logic [31:0] a;
    int g;
    rst_n = 1'b0; req_valid = 1'b0; mem_we = 1'b0; sel = 3'b000;
    addr = 32'h0; wdata = 32'h0; gnt = 1'b0; rvalid = 1'b0; drdata = 32'h0;
    #12;
    chk("rst_req", dreq, 0);
    chk("rst_stall", stall, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_be", dbe, 0);
    @(negedge clk);
    rst_n = 1'b1;

    access(1'b0, 3'b010, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF);          // LW
    chk("lw_val", rdata, 32'hDEADBEEF);
    access(1'b0, 3'b000, 32'h103, 32'h0, 0, 0, 32'h80112233);          // LB
    chk("lb_val", rdata, 32'hFFFFFF80);
    access(1'b0, 3'b100, 32'h103, 32'h0, 0, 1, 32'h80112233);          // LBU
    chk("lbu_val", rdata, 32'h00000080);
    access(1'b1, 3'b001, 32'h202, 32'h1234ABCD, 3, 0, 32'h0);          // SH
    access(1'b0, 3'b001, 32'h101, 32'h0, 0, 0, 32'h0);                 // LH misaligned
    access(1'b0, 3'b010, 32'h300, 32'h0, 1000, 0, 32'h0);              // LW timeout
    chk("to_keep", rdata, 32'h00000080);
    access(1'b0, 3'b010, 32'h304, 32'h0, 1, 3, 32'h12345678);          // rvalid too late
    access(1'b0, 3'b011, 32'h0, 32'h0, 0, 0, 32'h0);                   // illegal sel

    // Reset while waiting for read data.
    @(negedge clk);
    req_valid = 1'b1; mem_we = 1'b0; sel = 3'b010; addr = 32'h40;
    @(negedge clk);
    req_valid = 1'b0; gnt = 1'b1;
    @(negedge clk);
    gnt = 1'b0;
    #1;
    chk("wr_stall", stall, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", dreq, 0);
    chk("mid_rst_stall", stall, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_rdata", rdata, 0);
    exp_rdata = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    access(1'b1, 3'b000, 32'h51, 32'hA5A5_C3C3, 1, 0, 32'h0);          // SB

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0, 1:    s = 3'b000;
        2, 3:    s = 3'b001;
        4, 5:    s = 3'b010;
        6:       s = 3'b100;
        7, 8:    s = 3'b101;
        default: s = 3'($urandom_range(6, 7));
      endcase
      a = $urandom;
      if ($urandom_range(0, 2) != 0) a[1:0] = (s[1:0] == 2'b10) ? 2'b00 : {a[1], 1'b0};
      g = ($urandom_range(0, 7) == 0) ? 9 : $urandom_range(0, 3);
      access(1'($urandom_range(0, 1)), s, a, $urandom, g, $urandom_range(0, 3), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
